serial_adder_decoder: RTL and testbench

Parametrised multi-cycle adder that adds two WIDTH-bit operands plus carry-in, BITS_PER_CYCLE bits per clock. Each bit slice is a full adder built from a 3-to-8 decoder with OR-combined outputs, extending the decoder-based half-adder style to full width. A start/busy/done handshake wraps the datapath. It serves as the arithmetic building block for the decoder-logic section of the design.

---
 rtl/serial_adder_decoder.sv | 169 ++++++++++++++++
 tb/tb_serial_adder_decoder.sv | 242 ++++++++++++++++++++++++
 2 files changed

// File: rtl/serial_adder_decoder.sv
// -----------------------------------------------------------------------------
// serial_adder_decoder
//
// Multi-cycle adder: adds two WIDTH-bit operands plus a carry-in,
// BITS_PER_CYCLE bits per clock. Every bit slice is a full adder made from a
// 3-to-8 decoder whose outputs are OR-combined into sum and carry. The slices
// of one chunk ripple combinationally; successive chunks are chained through
// a carry register. A start/busy/done handshake wraps the datapath.
//
// Parameters
//   WIDTH           operand / result width (>= 1)
//   BITS_PER_CYCLE  bits handled per RUN cycle; must divide WIDTH exactly
//
// Ports
//   clk    in   rising-edge clock
//   rst    in   asynchronous, active-high reset
//   start  in   request; sampled on a rising edge when not running
//   a, b   in   operands, sampled with start
//   cin    in   carry-in, sampled with start
//   sub    in   (only with SERIAL_ADDER_SUB_EN) subtract a - b, sampled
//               with start; cin is ignored, cout = 1 means no borrow
//   busy   out  high while the datapath is running
//   done   out  one-cycle pulse: sum and cout hold a fresh result
//   sum    out  registered result (mod 2^WIDTH), held until next completion
//   cout   out  registered carry-out, held with sum
//
// Optional feature macro: SERIAL_ADDER_SUB_EN (adds the sub port).
//
// Timing: start taken at edge E0 (busy from E0), chunk k added at E(k+1),
// result and done appear after E(N) with N = WIDTH / BITS_PER_CYCLE.
// -----------------------------------------------------------------------------
module serial_adder_decoder #(
  parameter int unsigned WIDTH          = 8,
  parameter int unsigned BITS_PER_CYCLE = 1
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             start,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  input  logic             cin,
`ifdef SERIAL_ADDER_SUB_EN
  input  logic             sub,
`endif
  output logic             busy,
  output logic             done,
  output logic [WIDTH-1:0] sum,
  output logic             cout
);

  localparam int unsigned N  = WIDTH / BITS_PER_CYCLE;
  localparam int unsigned CW = (N > 1) ? $clog2(N) : 1;
  localparam logic [CW-1:0] LAST = CW'(N - 1);

  if (WIDTH < 1 || BITS_PER_CYCLE < 1 || (WIDTH % BITS_PER_CYCLE) != 0) begin : g_bad_cfg
    $error("serial_adder_decoder: BITS_PER_CYCLE must be >= 1 and divide WIDTH");
  end

  typedef enum logic [1:0] {
    S_IDLE,
    S_RUN,
    S_DONE
  } state_t;

  state_t                    r_state;
  logic [WIDTH-1:0]          r_a;
  logic [WIDTH-1:0]          r_b;
  logic [WIDTH-1:0]          r_sum_sr;
  logic                      r_carry;
  logic [CW-1:0]             r_cnt;

  logic [WIDTH-1:0]          w_b_load;
  logic                      w_c_load;
  logic [BITS_PER_CYCLE-1:0] w_chunk;
  logic                      w_carry_out;
  logic [WIDTH-1:0]          w_sum_next;

  // Values captured into the operand/carry registers when a request is taken.
  always_comb begin
`ifdef SERIAL_ADDER_SUB_EN
    // a - b == a + ~b + 1; carry-out then reads as "no borrow".
    w_b_load = sub ? ~b : b;
    w_c_load = sub ? 1'b1 : cin;
`else
    w_b_load = b;
    w_c_load = cin;
`endif
  end

  // One chunk of decoder-based full adders, rippling from bit 0 upward.
  always_comb begin
    logic       c;
    logic [7:0] dec;
    c       = r_carry;
    dec     = '0;
    w_chunk = '0;
    for (int unsigned i = 0; i < BITS_PER_CYCLE; i++) begin
      dec        = 8'd1 << {r_a[i], r_b[i], c};
      w_chunk[i] = dec[1] | dec[2] | dec[4] | dec[7];
      c          = dec[3] | dec[5] | dec[6] | dec[7];
    end
    w_carry_out = c;
  end

  // Result chunks enter at the top and move down, so after N cycles the
  // first (least significant) chunk has reached bit 0.
  always_comb begin
    logic [WIDTH-1:0] ext;
    ext                      = '0;
    ext[BITS_PER_CYCLE-1:0]  = w_chunk;
    w_sum_next = (r_sum_sr >> BITS_PER_CYCLE) | (ext << (WIDTH - BITS_PER_CYCLE));
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_state  <= S_IDLE;
      r_a      <= '0;
      r_b      <= '0;
      r_sum_sr <= '0;
      r_carry  <= 1'b0;
      r_cnt    <= '0;
      busy     <= 1'b0;
      done     <= 1'b0;
      sum      <= '0;
      cout     <= 1'b0;
    end else begin
      unique case (r_state)
        // IDLE and DONE accept a request identically; DONE also drops the
        // done pulse, which makes a same-cycle restart still a 1-cycle pulse.
        S_IDLE, S_DONE: begin
          done <= 1'b0;
          if (start) begin
            r_a      <= a;
            r_b      <= w_b_load;
            r_carry  <= w_c_load;
            r_sum_sr <= '0;
            r_cnt    <= '0;
            busy     <= 1'b1;
            r_state  <= S_RUN;
          end else begin
            r_state  <= S_IDLE;
          end
        end

        S_RUN: begin
          r_a      <= r_a >> BITS_PER_CYCLE;
          r_b      <= r_b >> BITS_PER_CYCLE;
          r_carry  <= w_carry_out;
          r_sum_sr <= w_sum_next;
          r_cnt    <= r_cnt + 1'b1;
          if (r_cnt == LAST) begin
            sum     <= w_sum_next;
            cout    <= w_carry_out;
            busy    <= 1'b0;
            done    <= 1'b1;
            r_state <= S_DONE;
          end
        end

        default: begin
          busy    <= 1'b0;
          done    <= 1'b0;
          r_state <= S_IDLE;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_serial_adder_decoder.sv
module tb_serial_adder_decoder;

  logic       clk = 1'b0;
  logic       rst;
  logic       st  [3];
  logic [7:0] ta  [3];
  logic [7:0] tbv [3];
  logic       tc  [3];
  logic       sb  [3];
  logic       bz  [3];
  logic       dn  [3];
  logic [7:0] sm  [3];
  logic       co  [3];

  int nn [3];
  int nchk  = 0;
  int nfail = 0;

  always #5 clk = ~clk;

  serial_adder_decoder #(.WIDTH(8), .BITS_PER_CYCLE(1)) u1 (
    .clk(clk), .rst(rst), .start(st[0]), .a(ta[0]), .b(tbv[0]), .cin(tc[0]),
`ifdef SERIAL_ADDER_SUB_EN
    .sub(sb[0]),
`endif
    .busy(bz[0]), .done(dn[0]), .sum(sm[0]), .cout(co[0]));

  serial_adder_decoder #(.WIDTH(8), .BITS_PER_CYCLE(4)) u4 (
    .clk(clk), .rst(rst), .start(st[1]), .a(ta[1]), .b(tbv[1]), .cin(tc[1]),
`ifdef SERIAL_ADDER_SUB_EN
    .sub(sb[1]),
`endif
    .busy(bz[1]), .done(dn[1]), .sum(sm[1]), .cout(co[1]));

  serial_adder_decoder #(.WIDTH(8), .BITS_PER_CYCLE(8)) u8 (
    .clk(clk), .rst(rst), .start(st[2]), .a(ta[2]), .b(tbv[2]), .cin(tc[2]),
`ifdef SERIAL_ADDER_SUB_EN
    .sub(sb[2]),
`endif
    .busy(bz[2]), .done(dn[2]), .sum(sm[2]), .cout(co[2]));

  // Reference: plain 9-bit arithmetic; subtraction as a + (255 - b) + 1.
  function automatic logic [8:0] model(input logic [7:0] av, input logic [7:0] bv,
                                       input logic cv, input logic sv);
    logic [7:0] nb;
    nb = ~bv;
    if (sv) return {1'b0, av} + {1'b0, nb} + 9'd1;
    return {1'b0, av} + {1'b0, bv} + {8'd0, cv};
  endfunction

  // Issue one request on instance i (called at a negedge) and wait, bounded,
  // for done. edges counts rising edges from the request to done visible.
  task automatic do_op(input int i, input logic [7:0] av, input logic [7:0] bv,
                       input logic cv, input logic sv,
                       output int edges, output int busy_cyc);
    ta[i]  = av;
    tbv[i] = bv;
    tc[i]  = cv;
    sb[i]  = sv;
    st[i]  = 1'b1;
    @(negedge clk);
    st[i]    = 1'b0;
    edges    = 1;
    busy_cyc = 0;
    while (dn[i] !== 1'b1 && edges < 64) begin
      if (bz[i] === 1'b1) busy_cyc++;
      @(negedge clk);
      edges++;
    end
  endtask

  task automatic test_reset;
    rst = 1'b1;
    repeat (2) @(negedge clk);
    for (int i = 0; i < 3; i++) begin
      nchk++; if (bz[i] !== 1'b0) begin nfail++; $display("FAIL reset_busy[%0d] got %b want 0", i, bz[i]); end
      nchk++; if (dn[i] !== 1'b0) begin nfail++; $display("FAIL reset_done[%0d] got %b want 0", i, dn[i]); end
      nchk++; if (sm[i] !== 8'h00) begin nfail++; $display("FAIL reset_sum[%0d] got %h want 00", i, sm[i]); end
      nchk++; if (co[i] !== 1'b0) begin nfail++; $display("FAIL reset_cout[%0d] got %b want 0", i, co[i]); end
    end
    rst = 1'b0;
    @(negedge clk);
  endtask

  task automatic test_basic;
    logic [7:0] va [3] = '{8'h5A, 8'hFF, 8'hFF};
    logic [7:0] vb [3] = '{8'h3C, 8'h01, 8'hFF};
    logic       vc [3] = '{1'b0, 1'b0, 1'b1};
    logic [8:0] exp_v;
    int edges, bcyc;
    for (int k = 0; k < 3; k++) begin
      exp_v = model(va[k], vb[k], vc[k], 1'b0);
      do_op(0, va[k], vb[k], vc[k], 1'b0, edges, bcyc);
      nchk++; if (edges != 9) begin nfail++; $display("FAIL basic_latency[%0d] got %0d want 9", k, edges); end
      nchk++; if (bcyc != 8) begin nfail++; $display("FAIL basic_busy_cycles[%0d] got %0d want 8", k, bcyc); end
      nchk++; if (sm[0] !== exp_v[7:0]) begin nfail++; $display("FAIL basic_sum[%0d] got %h want %h", k, sm[0], exp_v[7:0]); end
      nchk++; if (co[0] !== exp_v[8]) begin nfail++; $display("FAIL basic_cout[%0d] got %b want %b", k, co[0], exp_v[8]); end
      @(negedge clk);
      nchk++; if (dn[0] !== 1'b0) begin nfail++; $display("FAIL basic_done_pulse[%0d] got %b want 0", k, dn[0]); end
    end
  endtask

  task automatic test_random;
    logic [7:0] av, bv;
    logic       cv, sv;
    logic [8:0] exp_v;
    int edges, bcyc;
    for (int i = 0; i < 3; i++) begin
      for (int k = 0; k < 20; k++) begin
        av = 8'($urandom);
        bv = 8'($urandom);
        cv = 1'($urandom);
        sv = 1'b0;
`ifdef SERIAL_ADDER_SUB_EN
        sv = 1'($urandom);
`endif
        exp_v = model(av, bv, cv, sv);
        do_op(i, av, bv, cv, sv, edges, bcyc);
        nchk++; if (edges != nn[i] + 1) begin nfail++; $display("FAIL rand_latency[%0d] got %0d want %0d", i, edges, nn[i] + 1); end
        nchk++; if (bcyc != nn[i]) begin nfail++; $display("FAIL rand_busy[%0d] got %0d want %0d", i, bcyc, nn[i]); end
        nchk++; if (sm[i] !== exp_v[7:0]) begin nfail++; $display("FAIL rand_sum[%0d] a=%h b=%h c=%b s=%b got %h want %h", i, av, bv, cv, sv, sm[i], exp_v[7:0]); end
        nchk++; if (co[i] !== exp_v[8]) begin nfail++; $display("FAIL rand_cout[%0d] a=%h b=%h c=%b s=%b got %b want %b", i, av, bv, cv, sv, co[i], exp_v[8]); end
        @(negedge clk);
        nchk++; if (dn[i] !== 1'b0 || bz[i] !== 1'b0) begin nfail++; $display("FAIL rand_idle[%0d] got done=%b busy=%b want 0 0", i, dn[i], bz[i]); end
      end
    end
  endtask

  task automatic test_back_to_back;
    int edges, bcyc;
    do_op(1, 8'h5A, 8'h3C, 1'b0, 1'b0, edges, bcyc);
    nchk++; if (edges != 3) begin nfail++; $display("FAIL b2b_first_latency got %0d want 3", edges); end
    nchk++; if (sm[1] !== 8'h96) begin nfail++; $display("FAIL b2b_first_sum got %h want 96", sm[1]); end
    // restart in the done cycle
    ta[1] = 8'h01; tbv[1] = 8'h02; tc[1] = 1'b0; st[1] = 1'b1;
    @(negedge clk);
    st[1] = 1'b0;
    edges = 1;
    nchk++; if (dn[1] !== 1'b0) begin nfail++; $display("FAIL b2b_done_one_cycle got %b want 0", dn[1]); end
    nchk++; if (bz[1] !== 1'b1) begin nfail++; $display("FAIL b2b_busy_restart got %b want 1", bz[1]); end
    nchk++; if (sm[1] !== 8'h96) begin nfail++; $display("FAIL b2b_sum_held got %h want 96", sm[1]); end
    while (dn[1] !== 1'b1 && edges < 64) begin
      @(negedge clk);
      edges++;
    end
    nchk++; if (edges != 3) begin nfail++; $display("FAIL b2b_second_latency got %0d want 3", edges); end
    nchk++; if (sm[1] !== 8'h03) begin nfail++; $display("FAIL b2b_second_sum got %h want 03", sm[1]); end
    nchk++; if (co[1] !== 1'b0) begin nfail++; $display("FAIL b2b_second_cout got %b want 0", co[1]); end
    @(negedge clk);
    nchk++; if (dn[1] !== 1'b0) begin nfail++; $display("FAIL b2b_second_pulse got %b want 0", dn[1]); end
  endtask

  task automatic test_ignore_start;
    int pulses;
    logic [7:0] seen_sum;
    logic       seen_cout;
    pulses = 0; seen_sum = 8'h00; seen_cout = 1'b1;
    ta[0] = 8'h5A; tbv[0] = 8'h3C; tc[0] = 1'b0; st[0] = 1'b1;
    @(negedge clk); st[0] = 1'b0;   // RUN cycle 1
    @(negedge clk);                 // RUN cycle 2
    @(negedge clk);                 // RUN cycle 3: stray request
    ta[0] = 8'hFF; tbv[0] = 8'hFF; tc[0] = 1'b1; st[0] = 1'b1;
    @(negedge clk); st[0] = 1'b0;
    for (int k = 0; k < 20; k++) begin
      if (dn[0] === 1'b1) begin
        pulses++;
        seen_sum  = sm[0];
        seen_cout = co[0];
      end
      @(negedge clk);
    end
    nchk++; if (pulses != 1) begin nfail++; $display("FAIL ignore_pulses got %0d want 1", pulses); end
    nchk++; if (seen_sum !== 8'h96) begin nfail++; $display("FAIL ignore_sum got %h want 96", seen_sum); end
    nchk++; if (seen_cout !== 1'b0) begin nfail++; $display("FAIL ignore_cout got %b want 0", seen_cout); end
    nchk++; if (bz[0] !== 1'b0) begin nfail++; $display("FAIL ignore_busy_after got %b want 0", bz[0]); end
  endtask

  task automatic test_reset_midrun;
    int pulses, edges, bcyc;
    ta[0] = 8'hFF; tbv[0] = 8'hFF; tc[0] = 1'b1; st[0] = 1'b1;
    @(negedge clk); st[0] = 1'b0;
    repeat (3) @(negedge clk);      // inside RUN cycle 4
    rst = 1'b1;
    #1;
    nchk++; if (bz[0] !== 1'b0) begin nfail++; $display("FAIL midrst_busy got %b want 0", bz[0]); end
    nchk++; if (dn[0] !== 1'b0) begin nfail++; $display("FAIL midrst_done got %b want 0", dn[0]); end
    nchk++; if (sm[0] !== 8'h00) begin nfail++; $display("FAIL midrst_sum got %h want 00", sm[0]); end
    nchk++; if (co[0] !== 1'b0) begin nfail++; $display("FAIL midrst_cout got %b want 0", co[0]); end
    @(negedge clk);
    rst = 1'b0;
    pulses = 0;
    for (int k = 0; k < 15; k++) begin
      @(negedge clk);
      if (dn[0] === 1'b1 || bz[0] === 1'b1) pulses++;
    end
    nchk++; if (pulses != 0) begin nfail++; $display("FAIL midrst_no_done got %0d active cycles want 0", pulses); end
    do_op(0, 8'h10, 8'h20, 1'b0, 1'b0, edges, bcyc);
    nchk++; if (edges != 9) begin nfail++; $display("FAIL midrst_next_latency got %0d want 9", edges); end
    nchk++; if (sm[0] !== 8'h30) begin nfail++; $display("FAIL midrst_next_sum got %h want 30", sm[0]); end
    nchk++; if (co[0] !== 1'b0) begin nfail++; $display("FAIL midrst_next_cout got %b want 0", co[0]); end
    @(negedge clk);
  endtask

`ifdef SERIAL_ADDER_SUB_EN
  task automatic test_sub;
    int edges, bcyc;
    do_op(0, 8'h10, 8'h01, 1'b0, 1'b1, edges, bcyc);
    nchk++; if (sm[0] !== 8'h0F) begin nfail++; $display("FAIL sub1_sum got %h want 0F", sm[0]); end
    nchk++; if (co[0] !== 1'b1) begin nfail++; $display("FAIL sub1_cout got %b want 1", co[0]); end
    do_op(0, 8'h01, 8'h02, 1'b1, 1'b1, edges, bcyc);
    nchk++; if (sm[0] !== 8'hFF) begin nfail++; $display("FAIL sub2_sum got %h want FF", sm[0]); end
    nchk++; if (co[0] !== 1'b0) begin nfail++; $display("FAIL sub2_cout got %b want 0", co[0]); end
    @(negedge clk);
  endtask
`endif

  initial begin
    #1000000;
    $display("FAIL watchdog expired before end of test");
    $fatal(1);
  end

  initial begin
    nn[0] = 8; nn[1] = 2; nn[2] = 1;
    rst = 1'b1;
    for (int i = 0; i < 3; i++) begin
      st[i] = 1'b0; ta[i] = 8'h00; tbv[i] = 8'h00; tc[i] = 1'b0; sb[i] = 1'b0;
    end
    test_reset();
    test_basic();
    test_back_to_back();
    test_ignore_start();
    test_reset_midrun();
`ifdef SERIAL_ADDER_SUB_EN
    test_sub();
`endif
    test_random();
    $display("End of test - %0d assertions evaluated, %0d failures", nchk, nfail);
    $finish;
  end

endmodule
